// File: rtl/bin_window_gen_pkg.sv
// Shared constants and helpers for the binary sliding-window generator and
// the convolution stage that consumes its recField output.
package bin_window_gen_pkg;

    localparam int KERNEL = 5;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Bit position of window row r, column c; weight packing must use the same map.
    function automatic int rf_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/bin_line_buf.sv
// One-row delay line for 1-bit pixels: output is the pixel accepted `depth`
// enables ago. Synchronous clear so no earlier frame data survives reset.
module bin_line_buf
    import bin_window_gen_pkg::*;
#(
    parameter int depth = IMG_W
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [depth-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (en) begin
            sr <= {sr[depth-2:0], din};
        end
    end

    assign dout = sr[depth-1];

endmodule

// File: rtl/bin_window_gen.sv
// Streaming kernel x kernel window generator over a raster 1-bit pixel stream
// (no padding, stride 1) with a registered valid/ready output stage.
module bin_window_gen
    import bin_window_gen_pkg::*;
#(
    parameter int img_width  = IMG_W,
    parameter int img_height = IMG_H,
    parameter int kernel     = KERNEL
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_in,
    input  logic                       pix_valid,
    input  logic                       pix_sof,
    output logic                       pix_ready,
    output logic [kernel*kernel-1:0]   recField,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic                       win_last
);

    localparam int CW = clog2(img_width);
    localparam int RW = clog2(img_height);
    localparam int NB = kernel * kernel;

    logic                            accept;
    logic [CW-1:0]                   col;
    logic [CW-1:0]                   cur_col;
    logic [RW-1:0]                   row;
    logic [RW-1:0]                   cur_row;
    logic                            produce;
    logic                            frame_end;
    logic [kernel-2:0]               tap;
    logic [kernel-1:0]               col_in;
    logic [kernel-1:0][kernel-1:0]   win_p0;
    logic [kernel-1:0][kernel-1:0]   win_next;
    logic [NB-1:0]                   rf_next;

    assign pix_ready = !rst && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;

    // The current pixel's raster position; sof overrides the running counters.
    assign cur_col   = pix_sof ? '0 : col;
    assign cur_row   = pix_sof ? '0 : row;
    assign produce   = (cur_row >= RW'(kernel - 1)) && (cur_col >= CW'(kernel - 1));
    assign frame_end = (cur_row == RW'(img_height - 1)) && (cur_col == CW'(img_width - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (cur_col == CW'(img_width - 1)) begin
                col <= '0;
                row <= (cur_row == RW'(img_height - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // Tap i delays the stream by (i+1) rows and feeds window row kernel-2-i.
    for (genvar i = 0; i < kernel - 1; i++) begin : g_lb
        logic lb_in;
        if (i == 0) begin : g_head
            assign lb_in = pix_in;
        end else begin : g_chain
            assign lb_in = tap[i-1];
        end
        bin_line_buf #(.depth(img_width)) u_line_buf (
            .clk  (clk),
            .rst  (rst),
            .en   (accept),
            .din  (lb_in),
            .dout (tap[i])
        );
    end

    always_comb begin
        col_in = '0;
        for (int r = 0; r < kernel - 1; r++) begin
            col_in[r] = tap[kernel-2-r];
        end
        col_in[kernel-1] = pix_in;
    end

    // Shift every window row one column left; the newest column enters at kernel-1.
    always_comb begin
        win_next = win_p0;
        rf_next  = '0;
        for (int r = 0; r < kernel; r++) begin
            for (int c = 0; c < kernel - 1; c++) begin
                win_next[r][c] = win_p0[r][c+1];
            end
            win_next[r][kernel-1] = col_in[r];
        end
        for (int r = 0; r < kernel; r++) begin
            for (int c = 0; c < kernel; c++) begin
                rf_next[rf_idx(r, c, kernel)] = win_next[r][c];
            end
        end
    end

    // ---- stage p0 -> output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            win_p0    <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            recField  <= '0;
        end else begin
            if (accept) begin
                win_p0 <= win_next;
            end
            if (accept && produce) begin
                win_valid <= 1'b1;
                recField  <= rf_next;
                win_last  <= frame_end;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule
